// File: rtl/adder_result_checker.sv
// adder_result_checker: samples 4-bit adder operands, checks the sum c LAT cycles later.
// Optional stop-on-first-failure behaviour is enabled by defining ADDER_CHK_STOP_ON_FAIL_EN.
module adder_result_checker #(
  parameter  int unsigned LAT   = 1,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned OP_W  = 4,
  localparam int unsigned SUM_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [SUM_W-1:0] c,
  input  logic             clr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [OP_W-1:0]  err_a,
  output logic [OP_W-1:0]  err_b,
  output logic [SUM_W-1:0] err_c,
  output logic [SUM_W-1:0] err_exp,
  output logic             busy,
  output logic             halted
);

`ifdef ADDER_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  typedef struct packed {
    logic             vld;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic [SUM_W-1:0] exp;
  } chk_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  chk_t             w_new;
  chk_t             w_out;
  logic             w_run_ok;
  logic             w_launch;
  logic             w_cmp;
  logic             w_match;
  logic             w_first_fail;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err;
  logic [OP_W-1:0]  r_err_a;
  logic [OP_W-1:0]  r_err_b;
  logic [SUM_W-1:0] r_err_c;
  logic [SUM_W-1:0] r_err_exp;

  // Launch and compare qualification; clr and HALT both suppress activity.
  assign w_run_ok     = (r_state != S_HALT);
  assign w_launch     = op_valid & ~clr & w_run_ok;
  assign w_new        = {w_launch, a, b, SUM_W'(a) + SUM_W'(b)};
  assign w_cmp        = w_out.vld & ~clr & w_run_ok;
  assign w_match      = (c == w_out.exp);
  assign w_first_fail = w_cmp & ~w_match & ~r_err;

  generate
    if (LAT == 0) begin : g_nopipe
      assign w_out = w_new;
      assign busy  = 1'b0;
    end else begin : g_pipe
      chk_t           r_pipe [LAT];
      logic [LAT-1:0] w_vld;
      logic           w_flush;

      assign w_flush = clr | (STOP_EN & (w_first_fail | ~w_run_ok));

      // Fixed-latency shift pipeline carrying each launched check to its compare cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(LAT); i++) r_pipe[i] <= '0;
        end else if (w_flush) begin
          for (int i = 0; i < int'(LAT); i++) r_pipe[i].vld <= 1'b0;
        end else begin
          r_pipe[0] <= w_new;
          for (int i = 1; i < int'(LAT); i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      for (genvar i = 0; i < LAT; i++) begin : g_vld
        assign w_vld[i] = r_pipe[i].vld;
      end

      assign w_out = r_pipe[LAT-1];
      assign busy  = |w_vld;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (STOP_EN && w_first_fail) w_state_nxt = S_HALT;
        else if (op_valid)           w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (STOP_EN && w_first_fail) w_state_nxt = S_HALT;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clr) w_state_nxt = S_IDLE;
  end

  // Saturating counters and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_err_a    <= '0;
      r_err_b    <= '0;
      r_err_c    <= '0;
      r_err_exp  <= '0;
    end else if (clr) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_err_a    <= '0;
      r_err_b    <= '0;
      r_err_c    <= '0;
      r_err_exp  <= '0;
    end else if (w_cmp) begin
      if (w_match) begin
        if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end else begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        if (!r_err) begin
          r_err     <= 1'b1;
          r_err_a   <= w_out.a;
          r_err_b   <= w_out.b;
          r_err_c   <= c;
          r_err_exp <= w_out.exp;
        end
      end
    end
  end

`ifdef ADDER_CHK_STOP_ON_FAIL_EN
  logic r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_halted <= 1'b0;
    else     r_halted <= (w_state_nxt == S_HALT);
  end

  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif

  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  assign err      = r_err;
  assign err_a    = r_err_a;
  assign err_b    = r_err_b;
  assign err_c    = r_err_c;
  assign err_exp  = r_err_exp;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: instances at LAT=1, LAT=3, LAT=0/CNT_W=4 and LAT=2.
module tb_adder_result_checker;

`ifdef ADDER_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ov;
  logic [3:0]  tclr;
  logic [3:0]  ta   [4];
  logic [3:0]  tb_b [4];
  logic [6:0]  tc   [4];
  logic [15:0] pc0, fc0, pc1, fc1, pc3, fc3;
  logic [3:0]  pc2, fc2;
  logic        er [4];
  logic        bz [4];
  logic        hl [4];
  logic [3:0]  ea [4];
  logic [3:0]  eb [4];
  logic [6:0]  ec [4];
  logic [6:0]  ex [4];
  int          n_tot = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .rst(rst), .op_valid(ov[0]), .a(ta[0]), .b(tb_b[0]), .c(tc[0]), .clr(tclr[0]),
    .pass_cnt(pc0), .fail_cnt(fc0), .err(er[0]), .err_a(ea[0]), .err_b(eb[0]),
    .err_c(ec[0]), .err_exp(ex[0]), .busy(bz[0]), .halted(hl[0]));

  adder_result_checker #(.LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .rst(rst), .op_valid(ov[1]), .a(ta[1]), .b(tb_b[1]), .c(tc[1]), .clr(tclr[1]),
    .pass_cnt(pc1), .fail_cnt(fc1), .err(er[1]), .err_a(ea[1]), .err_b(eb[1]),
    .err_c(ec[1]), .err_exp(ex[1]), .busy(bz[1]), .halted(hl[1]));

  adder_result_checker #(.LAT(0), .CNT_W(4)) u_l0 (
    .clk(clk), .rst(rst), .op_valid(ov[2]), .a(ta[2]), .b(tb_b[2]), .c(tc[2]), .clr(tclr[2]),
    .pass_cnt(pc2), .fail_cnt(fc2), .err(er[2]), .err_a(ea[2]), .err_b(eb[2]),
    .err_c(ec[2]), .err_exp(ex[2]), .busy(bz[2]), .halted(hl[2]));

  adder_result_checker #(.LAT(2), .CNT_W(16)) u_l2 (
    .clk(clk), .rst(rst), .op_valid(ov[3]), .a(ta[3]), .b(tb_b[3]), .c(tc[3]), .clr(tclr[3]),
    .pass_cnt(pc3), .fail_cnt(fc3), .err(er[3]), .err_a(ea[3]), .err_b(eb[3]),
    .err_c(ec[3]), .err_exp(ex[3]), .busy(bz[3]), .halted(hl[3]));

  typedef struct {
    logic [3:0] xa;
    logic [3:0] xb;
    logic [6:0] xc;
    int         xp;
    int         xf;
    int         xe;
    int         xea;
    int         xeb;
    int         xec;
    int         xex;
  } vec_t;

  function automatic logic [31:0] gp(input int k);
    case (k)
      0:       gp = 32'(pc0);
      1:       gp = 32'(pc1);
      2:       gp = 32'(pc2);
      default: gp = 32'(pc3);
    endcase
  endfunction

  function automatic logic [31:0] gf(input int k);
    case (k)
      0:       gf = 32'(fc0);
      1:       gf = 32'(fc1);
      2:       gf = 32'(fc2);
      default: gf = 32'(fc3);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    n_tot++;
    if (act !== 32'(expv)) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, expv);
    end
  endtask

  initial begin
    vec_t v [8];
    int   ep, ef, ee, eea, eeb, eec, eex;
    bit   fr;

    v[0] = '{xa: 4'd6,  xb: 4'd4,  xc: 7'd10,  xp: 1, xf: 0, xe: 0, xea: 0, xeb: 0, xec: 0,  xex: 0};
    v[1] = '{xa: 4'd6,  xb: 4'd4,  xc: 7'd11,  xp: 1, xf: 1, xe: 1, xea: 6, xeb: 4, xec: 11, xex: 10};
    v[2] = '{xa: 4'd1,  xb: 4'd1,  xc: 7'd0,   xp: 1, xf: 2, xe: 1, xea: 6, xeb: 4, xec: 11, xex: 10};
    v[3] = '{xa: 4'd15, xb: 4'd15, xc: 7'd30,  xp: 2, xf: 2, xe: 1, xea: 6, xeb: 4, xec: 11, xex: 10};
    v[4] = '{xa: 4'd0,  xb: 4'd0,  xc: 7'd0,   xp: 3, xf: 2, xe: 1, xea: 6, xeb: 4, xec: 11, xex: 10};
    v[5] = '{xa: 4'd15, xb: 4'd15, xc: 7'd127, xp: 3, xf: 3, xe: 1, xea: 6, xeb: 4, xec: 11, xex: 10};
    v[6] = '{xa: 4'd9,  xb: 4'd7,  xc: 7'd16,  xp: 4, xf: 3, xe: 1, xea: 6, xeb: 4, xec: 11, xex: 10};
    v[7] = '{xa: 4'd0,  xb: 4'd0,  xc: 7'd64,  xp: 4, xf: 4, xe: 1, xea: 6, xeb: 4, xec: 11, xex: 10};

    rst  = 1'b1;
    ov   = '0;
    tclr = '0;
    for (int k = 0; k < 4; k++) begin
      ta[k] = '0; tb_b[k] = '0; tc[k] = 7'h7F;
    end
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_pass[%0d]", k), gp(k), 0);
      chk($sformatf("rst_fail[%0d]", k), gf(k), 0);
      chk($sformatf("rst_err[%0d]", k), 32'(er[k]), 0);
      chk($sformatf("rst_busy[%0d]", k), 32'(bz[k]), 0);
      chk($sformatf("rst_halt[%0d]", k), 32'(hl[k]), 0);
      chk($sformatf("rst_caps[%0d]", k), {ea[k], eb[k], ec[k], ex[k]}, 0);
    end
    rst = 1'b0;
    step();

    // LAT=1 table: one isolated check per entry, cumulative expectations
    ep = 0; ef = 0; ee = 0; eea = 0; eeb = 0; eec = 0; eex = 0;
    for (int i = 0; i < 8; i++) begin
      fr = STOP && (ee != 0);
      ov[0] = 1'b1; ta[0] = v[i].xa; tb_b[0] = v[i].xb; tc[0] = 7'h7F;
      step();
      ov[0] = 1'b0; ta[0] = ~v[i].xa; tb_b[0] = ~v[i].xb; tc[0] = v[i].xc;
      chk($sformatf("l1_busy_pend[%0d]", i), 32'(bz[0]), fr ? 0 : 1);
      step();
      tc[0] = 7'h7F;
      if (!fr) begin
        ep = v[i].xp; ef = v[i].xf; ee = v[i].xe;
        eea = v[i].xea; eeb = v[i].xeb; eec = v[i].xec; eex = v[i].xex;
      end
      chk($sformatf("l1_busy_done[%0d]", i), 32'(bz[0]), 0);
      chk($sformatf("l1_pass[%0d]", i), gp(0), ep);
      chk($sformatf("l1_fail[%0d]", i), gf(0), ef);
      chk($sformatf("l1_err[%0d]", i), 32'(er[0]), ee);
      chk($sformatf("l1_err_a[%0d]", i), 32'(ea[0]), eea);
      chk($sformatf("l1_err_b[%0d]", i), 32'(eb[0]), eeb);
      chk($sformatf("l1_err_c[%0d]", i), 32'(ec[0]), eec);
      chk($sformatf("l1_err_exp[%0d]", i), 32'(ex[0]), eex);
      chk($sformatf("l1_halted[%0d]", i), 32'(hl[0]), (STOP && ee != 0) ? 1 : 0);
    end

    tclr[0] = 1'b1;
    step();
    tclr[0] = 1'b0;
    chk("l1_clr_pass", gp(0), 0);
    chk("l1_clr_fail", gf(0), 0);
    chk("l1_clr_err", 32'(er[0]), 0);
    chk("l1_clr_caps", {ea[0], eb[0], ec[0], ex[0]}, 0);
    chk("l1_clr_halt", 32'(hl[0]), 0);

    // clr in the compare cycle of a failing check discards it
    ov[0] = 1'b1; ta[0] = 4'd2; tb_b[0] = 4'd3;
    step();
    ov[0] = 1'b0; tc[0] = 7'd0; tclr[0] = 1'b1;
    step();
    tclr[0] = 1'b0; tc[0] = 7'h7F;
    chk("l1_clrcmp_fail", gf(0), 0);
    chk("l1_clrcmp_err", 32'(er[0]), 0);
    chk("l1_clrcmp_busy", 32'(bz[0]), 0);

    // op_valid together with clr is not launched
    ov[0] = 1'b1; tclr[0] = 1'b1; ta[0] = 4'd1; tb_b[0] = 4'd1;
    step();
    ov[0] = 1'b0; tclr[0] = 1'b0; tc[0] = 7'd2;
    chk("l1_clrlaunch_busy", 32'(bz[0]), 0);
    step();
    tc[0] = 7'h7F;
    chk("l1_clrlaunch_pass", gp(0), 0);

    // LAT=3: 16 back-to-back checks a=b=0..15
    for (int j = 0; j < 19; j++) begin
      ov[1]   = (j < 16);
      ta[1]   = 4'(j);
      tb_b[1] = 4'(j);
      tc[1]   = (j >= 3) ? 7'(2 * (j - 3)) : 7'h7F;
      step();
      chk($sformatf("l3_pass[%0d]", j), gp(1), (j >= 3) ? j - 2 : 0);
      chk($sformatf("l3_busy[%0d]", j), 32'(bz[1]), (j <= 17) ? 1 : 0);
    end
    ov[1] = 1'b0; tc[1] = 7'h7F;
    chk("l3_fail", gf(1), 0);
    chk("l3_err", 32'(er[1]), 0);

    // LAT=0, CNT_W=4: saturation of pass_cnt at 15
    for (int i = 0; i < 20; i++) begin
      ov[2]   = 1'b1;
      ta[2]   = 4'(i);
      tb_b[2] = 4'(3 * i);
      tc[2]   = 7'(ta[2]) + 7'(tb_b[2]);
      step();
      chk($sformatf("l0_pass[%0d]", i), gp(2), (i + 1 > 15) ? 15 : i + 1);
    end
    chk("l0_busy", 32'(bz[2]), 0);
    ta[2] = 4'd5; tb_b[2] = 4'd5; tc[2] = 7'd9;
    step();
    chk("l0_fail1", gf(2), 1);
    chk("l0_err1", 32'(er[2]), 1);
    chk("l0_caps1", {ea[2], eb[2], ec[2], ex[2]}, {4'd5, 4'd5, 7'd9, 7'd10});
    chk("l0_halt1", 32'(hl[2]), STOP ? 1 : 0);
    ta[2] = 4'd2; tb_b[2] = 4'd2; tc[2] = 7'd5;
    step();
    ov[2] = 1'b0; tc[2] = 7'h7F;
    chk("l0_fail2", gf(2), STOP ? 1 : 2);
    chk("l0_caps2", {ea[2], eb[2], ec[2], ex[2]}, {4'd5, 4'd5, 7'd9, 7'd10});
    chk("l0_pass_hold", gp(2), 15);
    tclr[2] = 1'b1;
    step();
    tclr[2] = 1'b0;
    chk("l0_clr_pass", gp(2), 0);
    chk("l0_clr_fail", gf(2), 0);
    chk("l0_clr_err", 32'(er[2]), 0);
    chk("l0_clr_halt", 32'(hl[2]), 0);

    // LAT=2: failing check followed by a correct one in flight
    ov[3] = 1'b1; ta[3] = 4'd3; tb_b[3] = 4'd3; tc[3] = 7'h7F;
    step();
    ta[3] = 4'd1; tb_b[3] = 4'd2;
    step();
    ov[3] = 1'b0; ta[3] = 4'd0; tb_b[3] = 4'd0; tc[3] = 7'd7;
    step();
    chk("l2_fail", gf(3), 1);
    chk("l2_err", 32'(er[3]), 1);
    chk("l2_halt", 32'(hl[3]), STOP ? 1 : 0);
    chk("l2_caps", {ea[3], eb[3], ec[3], ex[3]}, {4'd3, 4'd3, 7'd7, 7'd6});
    tc[3] = 7'd3;
    step();
    chk("l2_pass_inflight", gp(3), STOP ? 0 : 1);
    chk("l2_busy_after", 32'(bz[3]), 0);
    ov[3] = 1'b1; ta[3] = 4'd1; tb_b[3] = 4'd1; tc[3] = 7'h7F;
    step();
    ov[3] = 1'b0;
    chk("l2_busy_launch", 32'(bz[3]), STOP ? 0 : 1);
    step();
    tc[3] = 7'd2;
    step();
    tc[3] = 7'h7F;
    chk("l2_pass_late", gp(3), STOP ? 0 : 2);
    chk("l2_fail_late", gf(3), 1);
    tclr[3] = 1'b1;
    step();
    tclr[3] = 1'b0;
    chk("l2_clr_halt", 32'(hl[3]), 0);
    chk("l2_clr_fail", gf(3), 0);

    // rst with two checks pending on the LAT=3 instance
    ov[1] = 1'b1; ta[1] = 4'd1; tb_b[1] = 4'd1;
    step();
    ta[1] = 4'd2; tb_b[1] = 4'd2;
    step();
    ov[1] = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_mid_busy", 32'(bz[1]), 0);
    chk("rst_mid_pass", gp(1), 0);
    rst = 1'b0;
    tc[1] = 7'd2;
    step();
    tc[1] = 7'd4;
    step();
    tc[1] = 7'h7F;
    step();
    chk("rst_after_pass", gp(1), 0);
    chk("rst_after_fail", gf(1), 0);
    chk("rst_after_busy", 32'(bz[1]), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
